// File: rtl/div_cfg_pkg.sv
// Shared types and helpers for the divider configuration controller.
// The divisor rule lives here so the controller and any CSR logic agree on it.
package div_cfg_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        DRAIN,
        APPLY,
        LOCK
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // An even divider can only produce a 50% duty output for even divisors >= 2.
    function automatic logic is_valid_div(input int unsigned value);
        return (value[0] == 1'b0) && (value >= MIN_DIV);
    endfunction

endpackage

// File: rtl/div_cfg_ctrl_if.sv
// Valid/ready request channel used to ask the controller for a new divisor.
// The requester holds valid and the divisor steady until ready is seen.
interface div_cfg_ctrl_if #(
    parameter int unsigned WIDTH_NUM_DIV = 4
) ();

    logic                     cfg_valid;
    logic [WIDTH_NUM_DIV-1:0] cfg_num_div;
    logic                     cfg_ready;
    logic                     cfg_err;

    modport master (
        output cfg_valid,
        output cfg_num_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_num_div,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/div_edge_cnt.sv
// Counts rising edges of the divider output fed back on clk_div.
// Held clear while the divider is in reset so release never looks like an edge.
module div_edge_cnt #(
    parameter int unsigned LOCK_EDGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic clk_div,
    output logic done
);

    localparam int unsigned     CNT_W   = $clog2(LOCK_EDGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_EDGES);

    logic             clk_div_q;
    logic [CNT_W-1:0] cnt;
    logic             rise;

    assign rise = clk_div & ~clk_div_q;

    // Saturates at the terminal count; the controller leaves LOCK on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div_q <= 1'b0;
            cnt       <= '0;
        end else if (clear) begin
            clk_div_q <= 1'b0;
            cnt       <= '0;
        end else begin
            clk_div_q <= clk_div;
            if (rise && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign done = (cnt == CNT_MAX);

endmodule

// File: rtl/div_cfg_ctrl.sv
// Owns the even divider's divisor and reset; applies divisor changes glitch-free
// by resetting the divider only while its output is low, then waits for lock.
module div_cfg_ctrl
    import div_cfg_pkg::*;
#(
    parameter int unsigned WIDTH_NUM_DIV = 4,
    parameter int unsigned DEFAULT_DIV   = 4,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned LOCK_EDGES    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    div_cfg_ctrl_if.slave            cfg,
    output logic [WIDTH_NUM_DIV-1:0] num_div,
    output logic                     div_rst_n,
    input  logic                     clk_div,
    output logic                     locked
);

    localparam int unsigned             HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [WIDTH_NUM_DIV-1:0] DEF_DIV   = WIDTH_NUM_DIV'(DEFAULT_DIV);

    state_t                   state, state_next;
    logic [WIDTH_NUM_DIV-1:0] num_div_next;
    logic [WIDTH_NUM_DIV-1:0] pending, pending_next;
    logic                     div_rst_n_next;
    logic                     err_q, err_next;
    logic                     locked_next;
    logic [HOLD_W-1:0]        hold_cnt, hold_cnt_next;
    logic                     handshake;
    logic                     lock_done;
    logic                     req_valid_div;
    logic                     req_is_noop;

    assign cfg.cfg_ready = (state == IDLE);
    assign cfg.cfg_err   = err_q;
    assign handshake     = cfg.cfg_valid && cfg.cfg_ready;
    assign req_valid_div = is_valid_div(32'(cfg.cfg_num_div));
    assign req_is_noop   = (cfg.cfg_num_div == num_div) && locked;

    div_edge_cnt #(
        .LOCK_EDGES (LOCK_EDGES)
    ) u_edge_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (~div_rst_n),
        .clk_div (clk_div),
        .done    (lock_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            num_div   <= DEF_DIV;
            pending   <= DEF_DIV;
            div_rst_n <= 1'b0;
            err_q     <= 1'b0;
            locked    <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            num_div   <= num_div_next;
            pending   <= pending_next;
            div_rst_n <= div_rst_n_next;
            err_q     <= err_next;
            locked    <= locked_next;
            hold_cnt  <= hold_cnt_next;
        end
    end

    // num_div only moves in the DRAIN->APPLY step, which is also where the divider enters reset.
    always_comb begin
        state_next     = state;
        num_div_next   = num_div;
        pending_next   = pending;
        div_rst_n_next = div_rst_n;
        err_next       = 1'b0;
        locked_next    = locked;
        hold_cnt_next  = hold_cnt;

        case (state)
            INIT: begin
                div_rst_n_next = 1'b1;
                state_next     = LOCK;
            end
            IDLE: begin
                if (handshake) begin
                    if (!req_valid_div) begin
                        err_next = 1'b1;
                    end else if (!req_is_noop) begin
                        pending_next = cfg.cfg_num_div;
                        locked_next  = 1'b0;
                        state_next   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!clk_div) begin
                    div_rst_n_next = 1'b0;
                    num_div_next   = pending;
                    hold_cnt_next  = '0;
                    state_next     = APPLY;
                end
            end
            APPLY: begin
                hold_cnt_next = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    div_rst_n_next = 1'b1;
                    state_next     = LOCK;
                end
            end
            LOCK: begin
                if (lock_done) begin
                    locked_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// Bench for div_cfg_ctrl with a behavioural even divider closing the clk_div loop.
// Requests come from a vector table; expected outcomes flow through a scoreboard queue.
module tb_div_cfg_ctrl;

    localparam int W     = 4;
    localparam int DEF   = 4;
    localparam int HOLD  = 2;
    localparam int EDGES = 2;

    typedef struct {
        logic         err;
        logic         reseq;
        logic [W-1:0] num;
    } exp_t;

    typedef struct {
        logic [W-1:0] req;
        exp_t         e;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         clk_div = 1'b0;
    logic [W-1:0] num_div;
    logic         div_rst_n;
    logic         locked;
    int           div_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];

    logic         mon_low      = 1'b0;
    int           low_cnt      = 0;
    logic         prev_rst     = 1'b0;
    logic         prev_clk_div = 1'b0;
    logic [W-1:0] prev_num     = W'(DEF);

    div_cfg_ctrl_if #(.WIDTH_NUM_DIV(W)) cfg ();

    div_cfg_ctrl #(
        .WIDTH_NUM_DIV (W),
        .DEFAULT_DIV   (DEF),
        .HOLD_CYC      (HOLD),
        .LOCK_EDGES    (EDGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg),
        .num_div   (num_div),
        .div_rst_n (div_rst_n),
        .clk_div   (clk_div),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Behavioural divider_even: first rising edge N/2 cycles after release, period N.
    always @(posedge clk) begin
        if (!div_rst_n) begin
            div_cnt <= 0;
            clk_div <= 1'b0;
        end else if (div_cnt >= int'(num_div) / 2 - 1) begin
            div_cnt <= 0;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        check_output(name, {31'd0, actual}, {31'd0, expected});
    endtask

    // Divider-side invariants: divisor moves only under reset, reset starts with clk_div low, hold length.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_low  = 1'b0;
            prev_rst = 1'b0;
            prev_num = num_div;
        end else begin
            if (num_div !== prev_num) check_bit("num_div_change_in_reset", div_rst_n, 1'b0);
            if (prev_rst && !div_rst_n) begin
                check_bit("reset_while_clk_div_low", prev_clk_div, 1'b0);
                mon_low = 1'b1;
                low_cnt = 1;
            end else if (mon_low && !div_rst_n) begin
                low_cnt++;
            end else if (mon_low && div_rst_n) begin
                check_output("hold_cycles", low_cnt, HOLD);
                mon_low = 1'b0;
            end
            prev_rst = div_rst_n;
            prev_num = num_div;
        end
        prev_clk_div = clk_div;
    end

    task automatic wait_div_rst(input logic level, input string name);
        int n = 0;
        while (div_rst_n !== level && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_bit(name, div_rst_n, level);
    endtask

    task automatic wait_locked(output int cycles, input string name);
        int n = 0;
        while (locked !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        cycles = n;
        check_bit(name, locked, 1'b1);
    endtask

    // Second clk_div rise lands 3N/2 cycles after release; allow a few cycles of detect/flag delay.
    task automatic check_latency(input string name, input int cycles, input int n_div);
        logic ok;
        ok = (cycles >= 3 * n_div / 2) && (cycles <= 3 * n_div / 2 + 3);
        check_bit(name, ok, 1'b1);
    endtask

    task automatic apply_stimulus(input logic [W-1:0] req, input exp_t e);
        int n = 0;
        @(negedge clk);
        cfg.cfg_valid   = 1'b1;
        cfg.cfg_num_div = req;
        while (!cfg.cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit("handshake_ready", cfg.cfg_ready, 1'b1);
        @(posedge clk); #1;
        cfg.cfg_valid   = 1'b0;
        cfg.cfg_num_div = ~req;
        sb_q.push_back(e);
    endtask

    // Called at the sample point right after a handshake edge.
    task automatic score_result();
        exp_t e;
        int   cyc;
        logic stable;
        check_bit("sb_has_entry", sb_q.size() > 0, 1'b1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_bit("err_pulse", cfg.cfg_err, e.err);
        if (e.reseq) begin
            check_bit("locked_drop", locked, 1'b0);
            wait_div_rst(1'b0, "apply_start");
            wait_div_rst(1'b1, "apply_end");
            check_output("num_div_applied", 32'(num_div), 32'(e.num));
            wait_locked(cyc, "relock");
            check_latency("relock_latency", cyc, int'(e.num));
            check_bit("ready_after_lock", cfg.cfg_ready, 1'b1);
        end else begin
            @(posedge clk); #1;
            check_bit("err_one_cycle", cfg.cfg_err, 1'b0);
            stable = 1'b1;
            repeat (8) begin
                if (!div_rst_n || !locked) stable = 1'b0;
                @(posedge clk); #1;
            end
            check_bit("no_resequence", stable, 1'b1);
            check_output("num_div_kept", 32'(num_div), 32'(e.num));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[13];
        int   cyc;

        vecs[0]  = '{4'd8,  '{1'b0, 1'b1, 4'd8}};
        vecs[1]  = '{4'd5,  '{1'b1, 1'b0, 4'd8}};
        vecs[2]  = '{4'd0,  '{1'b1, 1'b0, 4'd8}};
        vecs[3]  = '{4'd8,  '{1'b0, 1'b0, 4'd8}};
        vecs[4]  = '{4'd4,  '{1'b0, 1'b1, 4'd4}};
        vecs[5]  = '{4'd5,  '{1'b1, 1'b0, 4'd4}};
        vecs[6]  = '{4'd0,  '{1'b1, 1'b0, 4'd4}};
        vecs[7]  = '{4'd4,  '{1'b0, 1'b0, 4'd4}};
        vecs[8]  = '{4'd2,  '{1'b0, 1'b1, 4'd2}};
        vecs[9]  = '{4'd15, '{1'b1, 1'b0, 4'd2}};
        vecs[10] = '{4'd14, '{1'b0, 1'b1, 4'd14}};
        vecs[11] = '{4'd1,  '{1'b1, 1'b0, 4'd14}};
        vecs[12] = '{4'd4,  '{1'b0, 1'b1, 4'd4}};

        cfg.cfg_valid   = 1'b0;
        cfg.cfg_num_div = '0;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_num_div", 32'(num_div), DEF);
        check_bit("rst_div_rst_n", div_rst_n, 1'b0);
        check_bit("rst_cfg_ready", cfg.cfg_ready, 1'b0);
        check_bit("rst_cfg_err", cfg.cfg_err, 1'b0);
        check_bit("rst_locked", locked, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_bit("init_release", div_rst_n, 1'b1);
        check_bit("init_not_locked", locked, 1'b0);
        wait_locked(cyc, "init_lock");
        check_latency("init_lock_latency", cyc, DEF);
        check_bit("init_ready", cfg.cfg_ready, 1'b1);

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].req, vecs[i].e);
            score_result();
        end

        $display("[TB] request held during LOCK");
        apply_stimulus(4'd8, '{1'b0, 1'b1, 4'd8});
        fork
            score_result();
            begin
                int n = 0;
                wait_div_rst(1'b0, "held_apply_start");
                wait_div_rst(1'b1, "held_apply_end");
                cfg.cfg_valid   = 1'b1;
                cfg.cfg_num_div = 4'd6;
                check_bit("held_not_ready", cfg.cfg_ready, 1'b0);
                while (!cfg.cfg_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check_bit("held_accept_locked", locked, 1'b1);
                check_output("held_num_div_before", 32'(num_div), 32'd8);
                @(posedge clk); #1;
                cfg.cfg_valid   = 1'b0;
                cfg.cfg_num_div = 4'd3;
                sb_q.push_back('{1'b0, 1'b1, 4'd6});
            end
        join
        score_result();

        $display("[TB] reset during APPLY");
        apply_stimulus(4'd8, '{1'b0, 1'b1, 4'd8});
        wait_div_rst(1'b0, "rst_apply_start");
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midrst_num_div", 32'(num_div), DEF);
        check_bit("midrst_div_rst_n", div_rst_n, 1'b0);
        check_bit("midrst_locked", locked, 1'b0);
        check_bit("midrst_ready", cfg.cfg_ready, 1'b0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_bit("reinit_release", div_rst_n, 1'b1);
        wait_locked(cyc, "reinit_lock");
        check_latency("reinit_lock_latency", cyc, DEF);
        check_output("reinit_num_div", 32'(num_div), DEF);
        check_bit("reinit_ready", cfg.cfg_ready, 1'b1);

        apply_stimulus(4'd6, '{1'b0, 1'b1, 4'd6});
        score_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
